funct_dispatch: RTL and testbench

Issue-side controller for the ALU datapath. It accepts one operation per request (6-bit function code plus operands) and registers the operands onto the ALU and shifter input buses. It drives the same 6-bit function code to the downstream result multiplexer. It also owns the HI/LO register pair: MULTU runs on an internal 32-cycle shift-add multiplier, and the pair feeds the multiplexer's HiOut/LoOut inputs.

---
 rtl/funct_dispatch.sv | 134 +++++++++++++
 tb/tb_funct_dispatch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/funct_dispatch.sv
// Issue-side controller for the ALU datapath: registers operands and function
// code, and owns the HI/LO pair fed by a 32-cycle shift-add unsigned multiplier.
module funct_dispatch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [4:0]  shamt,
  output logic [5:0]  Signal,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [4:0]  shamtOut,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t      state_r;
  logic [64:0] prod_r;
  logic [4:0]  cnt_r;
  logic [32:0] acc_s;
  logic [64:0] prod_next_s;

  function automatic logic is_legal(input logic [5:0] f);
    logic ok;
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT,
      F_SRL, F_MFHI, F_MFLO, F_MULTU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One shift-add multiplier step; the 33-bit accumulator absorbs the carry.
  always_comb begin
    acc_s       = prod_r[64:32];
    prod_next_s = 65'd0;
    if (prod_r[0]) begin
      acc_s = prod_r[64:32] + {1'b0, opA};
    end else begin
      acc_s = prod_r[64:32];
    end
    prod_next_s = {1'b0, acc_s, prod_r[31:1]};
  end

  // Control FSM with registered outputs and the HI/LO pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      prod_r   <= 65'd0;
      cnt_r    <= 5'd0;
      Signal   <= 6'd0;
      opA      <= 32'd0;
      opB      <= 32'd0;
      shamtOut <= 5'd0;
      HiOut    <= 32'd0;
      LoOut    <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            Signal   <= funct;
            opA      <= dataA;
            opB      <= dataB;
            shamtOut <= shamt;
            busy     <= 1'b1;
            prod_r   <= {33'd0, dataB};
            cnt_r    <= 5'd0;
            if (funct == F_MULTU) begin
              state_r <= MUL;
            end else begin
              state_r <= EXEC;
              done    <= 1'b1;
              illegal <= ~is_legal(funct);
            end
          end else begin
            busy <= 1'b0;
          end
        end
        // Result cycle: done is already visible; release busy on the next edge.
        EXEC: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        MUL: begin
          prod_r <= prod_next_s;
          cnt_r  <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            HiOut   <= prod_next_s[63:32];
            LoOut   <= prod_next_s[31:0];
            done    <= 1'b1;
            state_r <= EXEC;
          end else begin
            state_r <= MUL;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          illegal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_funct_dispatch.sv
// Self-checking bench for funct_dispatch: directed vector table, hand-written
// corner sequences and randomized ops against a behavioural model.
module tb_funct_dispatch;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  shamt;
  logic [5:0]  Signal;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  shamtOut;
  logic [31:0] HiOut;
  logic [31:0] LoOut;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  logic [5:0] legal [9] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO, F_MULTU};

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        inject;
    logic        ill;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tab [6];

  funct_dispatch dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .dataA(dataA), .dataB(dataB), .shamt(shamt),
    .Signal(Signal), .opA(opA), .opB(opB), .shamtOut(shamtOut),
    .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and follow it to completion; inject=1 adds ignored SUB starts while busy.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic inject, input logic exp_ill,
                       input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    start = 1'b1; funct = f; dataA = a; dataB = b; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0;
    check("signal_latch", {58'd0, Signal}, {58'd0, f});
    check("opA_latch", {32'd0, opA}, {32'd0, a});
    check("opB_latch", {32'd0, opB}, {32'd0, b});
    check("shamt_latch", {59'd0, shamtOut}, {59'd0, sh});
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      check("hilo_hold", {HiOut, LoOut}, {hi_m, lo_m});
      check("no_illegal_wait", {63'd0, illegal}, 64'd0);
      if (inject) begin
        @(negedge clk);
        start = 1'b1; funct = F_SUB; dataA = $urandom; dataB = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      check("signal_hold_busy", {58'd0, Signal}, {58'd0, f});
    end
    check("done_latency", 64'(n), 64'(exp_lat));
    check("illegal_flag", {63'd0, illegal}, {63'd0, exp_ill});
    check("busy_at_done", {63'd0, busy}, 64'd1);
    check("hi_result", {32'd0, HiOut}, {32'd0, exp_hi});
    check("lo_result", {32'd0, LoOut}, {32'd0, exp_lo});
    hi_m = exp_hi;
    lo_m = exp_lo;
    if (inject) begin
      @(negedge clk);
      start = 1'b1; funct = F_SUB; dataA = $urandom; dataB = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("illegal_one_cycle", {63'd0, illegal}, 64'd0);
    check("busy_released", {63'd0, busy}, 64'd0);
    check("signal_after_done", {58'd0, Signal}, {58'd0, f});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct = 6'd0; dataA = 32'd0; dataB = 32'd0; shamt = 5'd0;

    tab[0] = '{F_ADD,   32'd5,          32'd7,          5'd0, 1'b0, 1'b0, 0,  32'h0,        32'h0};
    tab[1] = '{F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0, 1'b0, 1'b0, 32, 32'hFFFF_FFFE, 32'h0000_0001};
    tab[2] = '{F_MFHI,  32'd0,          32'd0,          5'd0, 1'b0, 1'b0, 0,  32'hFFFF_FFFE, 32'h0000_0001};
    tab[3] = '{F_MULTU, 32'h0001_0000,  32'h0001_0000,  5'd0, 1'b1, 1'b0, 32, 32'h0000_0001, 32'h0};
    tab[4] = '{F_SRL,   32'd0,          32'h0000_00F0,  5'd4, 1'b1, 1'b0, 0,  32'h0000_0001, 32'h0};
    tab[5] = '{6'b111111, 32'h1234,     32'h5678,       5'd3, 1'b0, 1'b1, 0,  32'h0000_0001, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_signal", {58'd0, Signal}, 64'd0);
    check("rst_opA", {32'd0, opA}, 64'd0);
    check("rst_opB", {32'd0, opB}, 64'd0);
    check("rst_hilo", {HiOut, LoOut}, 64'd0);
    check("rst_flags", {61'd0, busy, done, illegal}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(tab[i].f, tab[i].a, tab[i].b, tab[i].sh, tab[i].inject,
            tab[i].ill, tab[i].lat, tab[i].hi, tab[i].lo);
    end

    // Asynchronous reset ten cycles into a multiply.
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; dataA = 32'hDEAD_BEEF; dataB = 32'h1357_9BDF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_outputs", {Signal, opA, opB}, 70'd0);
    check("async_rst_hilo", {HiOut, LoOut}, 64'd0);
    check("async_rst_flags", {61'd0, busy, done, illegal}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("no_done_in_reset", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk); #1;
    check("no_done_after_reset", {62'd0, done, busy}, 64'd0);
    issue(F_ADD, 32'd100, 32'd23, 5'd0, 1'b0, 1'b0, 0, 32'd0, 32'd0);

    // Randomized ops against the model: product of operands, legality by list lookup.
    for (int k = 0; k < 30; k++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [4:0]  sh;
      logic        ill;
      logic [63:0] prod;
      int          sel;
      sel = $urandom_range(0, 11);
      if (sel < 9) f = legal[sel];
      else if (sel == 9) f = 6'($urandom);
      else f = F_MULTU;
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom);
      if (k % 5 == 0) a = 32'd0;
      ill = 1'b1;
      for (int j = 0; j < 9; j++) if (legal[j] == f) ill = 1'b0;
      if (f == F_MULTU) begin
        prod = 64'(a) * 64'(b);
        issue(f, a, b, sh, k[0], ill, 32, prod[63:32], prod[31:0]);
      end else begin
        issue(f, a, b, sh, k[0], ill, 0, hi_m, lo_m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
